// File: rtl/operand_fetch_sb.sv
// Operand fetch front end: register-file read addressing, write-back bypass,
// per-register pending-write scoreboard and a one-entry valid/ready stage into EX.
module operand_fetch_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_rs,
  input  logic [ADDR_W-1:0] issue_rt,
  input  logic              issue_use_rs,
  input  logic              issue_use_rt,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_wen,
  output logic [ADDR_W-1:0] rf_rsc,
  output logic [ADDR_W-1:0] rf_rtc,
  output logic              rf_ena,
  input  logic [DATA_W-1:0] rf_rs,
  input  logic [DATA_W-1:0] rf_rt,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rdc,
  input  logic [DATA_W-1:0] wb_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_rd,
  output logic              op_wen,
  output logic              stall_raw,
  output logic              sb_err
);
  localparam int                NREG     = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};

  logic [CNT_W-1:0] cnt_r     [NREG];
  logic [CNT_W-1:0] cnt_nxt_s [NREG];
  logic             haz_rs_s;
  logic             haz_rt_s;
  logic             waw_s;
  logic             accept_s;
  logic             err_set_s;

  // A last pending write retiring this very cycle is covered by the bypass.
  function automatic logic src_hazard(input logic use_src, input logic [ADDR_W-1:0] src,
                                      input logic [CNT_W-1:0] cnt, input logic wbv,
                                      input logic [ADDR_W-1:0] wbr);
    return use_src && (src != REG_ZERO) && (cnt != CNT_ZERO) &&
           !(wbv && (wbr == src) && (cnt == CNT_ONE));
  endfunction

  function automatic logic [DATA_W-1:0] pick(input logic [ADDR_W-1:0] src,
                                             input logic [DATA_W-1:0] rf_d, input logic wbv,
                                             input logic [ADDR_W-1:0] wbr,
                                             input logic [DATA_W-1:0] wbd);
    if (src == REG_ZERO) begin
      return {DATA_W{1'b0}};
    end else if (wbv && (wbr == src)) begin
      return wbd;
    end else begin
      return rf_d;
    end
  endfunction

  assign rf_rsc = issue_rs;
  assign rf_rtc = issue_rt;

  // Hazard detection and issue handshake.
  always_comb begin
    haz_rs_s    = src_hazard(issue_use_rs, issue_rs, cnt_r[issue_rs], wb_valid, wb_rdc);
    haz_rt_s    = src_hazard(issue_use_rt, issue_rt, cnt_r[issue_rt], wb_valid, wb_rdc);
    waw_s       = issue_wen && (issue_rd != REG_ZERO) && (cnt_r[issue_rd] == CNT_MAX);
    stall_raw   = issue_valid && (haz_rs_s || haz_rt_s || waw_s);
    issue_ready = (!op_valid || op_ready) && !stall_raw && !flush;
    accept_s    = issue_valid && issue_ready;
  end

  // Scoreboard next state; a flush drops both new issues and retiring writes.
  always_comb begin
    err_set_s = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (flush || (i == 0)) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (accept_s && issue_wen && (issue_rd == ADDR_W'(i)) &&
                   wb_valid && (wb_rdc == ADDR_W'(i))) begin
        cnt_nxt_s[i] = cnt_r[i];
      end else if (accept_s && issue_wen && (issue_rd == ADDR_W'(i))) begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end else if (wb_valid && (wb_rdc == ADDR_W'(i))) begin
        if (cnt_r[i] == CNT_ZERO) begin
          cnt_nxt_s[i] = CNT_ZERO;
          err_set_s    = 1'b1;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Scoreboard counters and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      sb_err <= sb_err || err_set_s;
    end
  end

  // One-entry output stage toward EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid <= 1'b0;
      op_a     <= {DATA_W{1'b0}};
      op_b     <= {DATA_W{1'b0}};
      op_rd    <= REG_ZERO;
      op_wen   <= 1'b0;
    end else if (flush) begin
      op_valid <= 1'b0;
    end else if (accept_s) begin
      op_valid <= 1'b1;
      op_a     <= pick(issue_rs, rf_rs, wb_valid, wb_rdc, wb_data);
      op_b     <= pick(issue_rt, rf_rt, wb_valid, wb_rdc, wb_data);
      op_rd    <= issue_rd;
      op_wen   <= issue_wen;
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end else begin
      op_valid <= op_valid;
    end
  end

  // Register-file enable comes up on the first clock after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_ena <= 1'b0;
    end else begin
      rf_ena <= 1'b1;
    end
  end

endmodule
